hwpe_ctrl_uloop_bp: RTL and testbench
=====================================

// Module: hwpe_ctrl_uloop_bp
// PURPOSE
//  Parametrised nested-loop microcode sequencer for HWPE controllers. It generates per-iteration
//  address offsets (offs) and loop indices (idx) for streamers and engines. Loop count, register
//  count and widths are generic. Adds a valid/ready handshake with backpressure, zero-range loop
//  skipping and a programmable accumulation level. Sits between the controller regfile and the streamers.
// PARAMETERS
//  NB_LOOPS   6   number of nested loops; loop 0 is innermost
//  NB_REG     4   writable offset registers, exported on offs_o
//  NB_RO_REG  28  read-only operand registers, driven by ro_reg_i
//  LENGTH     16  microcode op slots
//  REG_WIDTH  32  offset register width
//  CNT_WIDTH  12  loop range/index width
//  (derived) RW=$clog2(NB_REG+NB_RO_REG), AW=$clog2(LENGTH), LW=$clog2(NB_LOOPS)
// PORTS
//  clk_i         in   1                        clock
//  rst_ni        in   1                        async reset, active low
//  clear_i       in   1                        sync clear, highest priority
//  enable_i      in   1                        0 freezes all state and masks valid_o
//  start_i       in   1                        starts a sequence (IDLE only)
//  accum_loop_i  in   LW                       accumulation level
//  loop_addr_i   in   NB_LOOPS*AW              first op slot of each loop
//  loop_nops_i   in   NB_LOOPS*(AW+1)          op count per loop (0..LENGTH)
//  range_i       in   NB_LOOPS*CNT_WIDTH       iterations per loop; 0 treated as 1
//  code_i        in   LENGTH*(1+2*RW)          per op {op_sel, a, b}
//  ro_reg_i      in   NB_RO_REG*REG_WIDTH      read-only operands
//  valid_o       out  1                        iteration output valid
//  ready_i       in   1                        consumer ready
//  offs_o        out  NB_REG*REG_WIDTH         offset registers
//  idx_o         out  NB_LOOPS*CNT_WIDTH       loop indices
//  accum_o       out  1                        idx[j]==0 for all j<accum_loop_i
//  busy_o        out  1                        state != IDLE
//  done_o        out  1                        one-cycle pulse after last handshake
// BEHAVIOUR
//  - Reset and clear: state IDLE; all regs and idx 0; valid_o/done_o/busy_o 0. accum_o is combinational from idx.
//  - Register file: index b<NB_REG selects a writable reg; b>=NB_REG selects ro_reg_i[b-NB_REG].
//    Index a must be <NB_REG; writes with a>=NB_REG are dropped.
//  - Ops: op_sel=1 -> reg[a]=reg[a]+opnd[b], mod 2^REG_WIDTH; op_sel=0 -> reg[a]=opnd[b]. One op per cycle.
//  - FSM IDLE->EMIT: on start_i (and enable_i). valid_o is high the next cycle with idx=0 and offs=0.
//  - EMIT: valid_o=enable_i. While valid_o&&!ready_i, offs_o, idx_o and accum_o hold stable.
//  - On handshake, find the lowest l with idx[l] < max(range[l],1)-1.
//      none found -> DONE for 1 cycle (done_o=1), then IDLE
//      found -> idx[l]++, idx[j<l]=0 in the same edge; go to EXEC if nops[l]>0, else stay in EMIT
//  - EXEC: runs ops loop_addr[l] .. loop_addr[l]+nops[l]-1, one per cycle; EMIT follows the last op.
//    Next valid_o comes nops[l]+1 cycles after the handshake, or 1 cycle if nops[l]=0.
//  - Op slot address wraps mod LENGTH.
//  - Total emissions per sequence = product over loops of max(range,1).
//  - start_i outside IDLE is ignored. clear_i with start_i: clear wins.
//  - enable_i=0: no transitions, no reg writes, valid_o=0, outputs held.
//  - Reset is async and clear is sync at any point, including mid-EXEC: immediate return to IDLE,
//    no done_o pulse.
//  - Config inputs must be stable while busy_o=1 and are not registered.
// TESTING
//  1 NB_LOOPS=2, range={3,2}, loop0 op reg0+=ro0(4), loop1 op reg1+=ro1(100), ready=1
//    -> idx (0,0)(1,0)(2,0)(0,1)(1,1)(2,1); offs0 0,4,8,8,12,16; offs1 0,0,0,100,100,100;
//       done_o 1 cycle after 6th handshake
//  2 Same program, ready_i low 5 cycles on 3rd emission
//    -> valid_o held, offs0=8 and idx=(2,0) stable, 6 emissions total
//  3 range={0,0}, start
//    -> exactly one emission (idx 0, offs 0), then done_o
//  4 accum_loop_i=1, range={2,2}
//    -> accum_o 1,0,1,0 across the four emissions
//  5 clear_i during EXEC; separately rst_ni low mid-sequence
//    -> IDLE next edge / immediately, offs=0, no done_o; restart matches test 1
//  6 op_sel=0 move reg0=ro2(0xFFFF_FFFF) then add ro0(1) in one loop
//    -> offs0 wraps to 0; enable_i=0 for 3 cycles freezes all state

Source files
------------

// File: rtl/hwpe_ctrl_uloop_bp.sv
// hwpe_ctrl_uloop_bp
//   Nested-loop microcode sequencer with a valid/ready output handshake.
//   Each accepted iteration advances a mixed-radix loop counter (loop 0 is
//   innermost). The microcode of the loop that advanced then runs, one op
//   per cycle, updating the writable offset registers.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   clear_i          synchronous clear, overrides every other input
//   enable_i         0 freezes all state and masks valid_o
//   start_i          starts a sequence (only honoured in IDLE)
//   accum_loop_i     accum_o looks at loops 0 .. accum_loop_i-1
//   loop_addr_i      first microcode slot of each loop
//   loop_nops_i      number of ops of each loop (0..LENGTH)
//   range_i          iterations per loop, 0 behaves as 1
//   code_i           microcode, {op_sel, a, b} per slot
//   ro_reg_i         read-only operands, operand index NB_REG and up
//   valid_o/ready_i  iteration handshake
//   offs_o, idx_o    offset registers and loop indices
//   accum_o          all selected inner indices are zero
//   busy_o, done_o   sequence active / one-cycle end pulse
module hwpe_ctrl_uloop_bp #(
  parameter int NB_LOOPS  = 6,
  parameter int NB_REG    = 4,
  parameter int NB_RO_REG = 28,
  parameter int LENGTH    = 16,
  parameter int REG_WIDTH = 32,
  parameter int CNT_WIDTH = 12,
  localparam int RW = $clog2(NB_REG + NB_RO_REG),
  localparam int AW = $clog2(LENGTH),
  localparam int LW = $clog2(NB_LOOPS)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic                            enable_i,
  input  logic                            start_i,
  input  logic [LW-1:0]                   accum_loop_i,
  input  logic [NB_LOOPS*AW-1:0]          loop_addr_i,
  input  logic [NB_LOOPS*(AW+1)-1:0]      loop_nops_i,
  input  logic [NB_LOOPS*CNT_WIDTH-1:0]   range_i,
  input  logic [LENGTH*(1+2*RW)-1:0]      code_i,
  input  logic [NB_RO_REG*REG_WIDTH-1:0]  ro_reg_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [NB_REG*REG_WIDTH-1:0]     offs_o,
  output logic [NB_LOOPS*CNT_WIDTH-1:0]   idx_o,
  output logic                            accum_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int OPW = 1 + 2*RW;

  typedef enum logic [1:0] {IDLE, EMIT, EXEC, DONE} state_e;

  state_e               state;
  logic [REG_WIDTH-1:0] regs [NB_REG];
  logic [CNT_WIDTH-1:0] idx  [NB_LOOPS];
  logic [LW-1:0]        cur_loop;
  logic [AW:0]          op_cnt;

  logic [AW-1:0]        laddr    [NB_LOOPS];
  logic [AW:0]          lnops    [NB_LOOPS];
  logic [CNT_WIDTH-1:0] last_idx [NB_LOOPS];

  logic                 inc_found;
  logic [LW-1:0]        inc_loop;

  logic [AW-1:0]        cur_base;
  logic [AW:0]          cur_nops;
  logic [AW-1:0]        op_addr;
  logic [OPW-1:0]       op_word;
  logic                 op_sel;
  logic [RW-1:0]        op_a;
  logic [RW-1:0]        op_b;
  logic [REG_WIDTH-1:0] opnd;
  logic [REG_WIDTH-1:0] tgt;
  logic [REG_WIDTH-1:0] wr_data;

  // A zero range behaves as a single iteration, so its last index is 0.
  function automatic logic [CNT_WIDTH-1:0] last_of(input logic [CNT_WIDTH-1:0] r);
    return (r == '0) ? '0 : r - 1'b1;
  endfunction

  // Register accumulation wraps modulo 2^REG_WIDTH.
  function automatic logic [REG_WIDTH-1:0] wrap_add(input logic [REG_WIDTH-1:0] x,
                                                    input logic [REG_WIDTH-1:0] y);
    return x + y;
  endfunction

  always_comb begin
    for (int l = 0; l < NB_LOOPS; l++) begin
      laddr[l]    = loop_addr_i[l*AW +: AW];
      lnops[l]    = loop_nops_i[l*(AW+1) +: AW+1];
      last_idx[l] = last_of(range_i[l*CNT_WIDTH +: CNT_WIDTH]);
    end
  end

  // Lowest loop that has not reached its last index; scanning downward
  // lets the lowest candidate overwrite the others.
  always_comb begin
    inc_found = 1'b0;
    inc_loop  = '0;
    for (int l = NB_LOOPS-1; l >= 0; l--) begin
      if (idx[l] < last_idx[l]) begin
        inc_found = 1'b1;
        inc_loop  = LW'(l);
      end
    end
  end

  // Decode of the op executed this cycle while in EXEC.
  always_comb begin
    cur_base = laddr[cur_loop];
    cur_nops = lnops[cur_loop];
    op_addr  = AW'((int'(cur_base) + int'(op_cnt)) % LENGTH);
    op_word  = code_i[op_addr*OPW +: OPW];
    {op_sel, op_a, op_b} = op_word;
    opnd = '0;
    for (int r = 0; r < NB_REG; r++)
      if (int'(op_b) == r) opnd = regs[r];
    for (int k = 0; k < NB_RO_REG; k++)
      if (int'(op_b) == NB_REG + k) opnd = ro_reg_i[k*REG_WIDTH +: REG_WIDTH];
    tgt = '0;
    for (int r = 0; r < NB_REG; r++)
      if (int'(op_a) == r) tgt = regs[r];
    wr_data = op_sel ? wrap_add(tgt, opnd) : opnd;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cur_loop <= '0;
      op_cnt   <= '0;
      for (int r = 0; r < NB_REG; r++)   regs[r] <= '0;
      for (int l = 0; l < NB_LOOPS; l++) idx[l]  <= '0;
    end else if (clear_i) begin
      state    <= IDLE;
      cur_loop <= '0;
      op_cnt   <= '0;
      for (int r = 0; r < NB_REG; r++)   regs[r] <= '0;
      for (int l = 0; l < NB_LOOPS; l++) idx[l]  <= '0;
    end else if (enable_i) begin
      case (state)
        IDLE: begin
          if (start_i) begin
            for (int r = 0; r < NB_REG; r++)   regs[r] <= '0;
            for (int l = 0; l < NB_LOOPS; l++) idx[l]  <= '0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (ready_i) begin
            if (!inc_found) begin
              state <= DONE;
            end else begin
              for (int l = 0; l < NB_LOOPS; l++) begin
                if (l < int'(inc_loop))       idx[l] <= '0;
                else if (l == int'(inc_loop)) idx[l] <= idx[l] + 1'b1;
              end
              cur_loop <= inc_loop;
              op_cnt   <= '0;
              state    <= (lnops[inc_loop] != '0) ? EXEC : EMIT;
            end
          end
        end
        EXEC: begin
          // Destinations outside the writable registers are simply dropped.
          for (int r = 0; r < NB_REG; r++)
            if (int'(op_a) == r) regs[r] <= wr_data;
          op_cnt <= op_cnt + 1'b1;
          if (op_cnt + 1'b1 >= cur_nops) state <= EMIT;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign valid_o = (state == EMIT) && enable_i;
  assign busy_o  = (state != IDLE);
  assign done_o  = (state == DONE);

  always_comb begin
    for (int r = 0; r < NB_REG; r++)   offs_o[r*REG_WIDTH +: REG_WIDTH] = regs[r];
    for (int l = 0; l < NB_LOOPS; l++) idx_o[l*CNT_WIDTH +: CNT_WIDTH]  = idx[l];
  end

  always_comb begin
    accum_o = 1'b1;
    for (int j = 0; j < NB_LOOPS; j++)
      if (j < int'(accum_loop_i) && idx[j] != '0) accum_o = 1'b0;
  end

endmodule

// File: tb/tb_hwpe_ctrl_uloop_bp.sv
// Bench for hwpe_ctrl_uloop_bp: directed tables, hand-written corner
// sequences and randomized programs against a mixed-radix counting model.
module tb_hwpe_ctrl_uloop_bp;
  localparam int NL = 6, NR = 4, NRO = 28, LEN = 16, RWD = 32, CW = 12;
  localparam int RW = 5, AW = 4, LW = 3, OPW = 11;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic clear_i = 1'b0, enable_i = 1'b1, start_i = 1'b0, ready_i = 1'b1;
  logic [LW-1:0]         accum_loop_i = '0;
  logic [NL*AW-1:0]      loop_addr_i = '0;
  logic [NL*(AW+1)-1:0]  loop_nops_i = '0;
  logic [NL*CW-1:0]      range_i = '0;
  logic [LEN*OPW-1:0]    code_i = '0;
  logic [NRO*RWD-1:0]    ro_reg_i = '0;
  logic                  valid_o, accum_o, busy_o, done_o;
  logic [NR*RWD-1:0]     offs_o;
  logic [NL*CW-1:0]      idx_o;

  always #5 clk = ~clk;

  hwpe_ctrl_uloop_bp dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
    .start_i(start_i), .accum_loop_i(accum_loop_i), .loop_addr_i(loop_addr_i),
    .loop_nops_i(loop_nops_i), .range_i(range_i), .code_i(code_i),
    .ro_reg_i(ro_reg_i), .valid_o(valid_o), .ready_i(ready_i), .offs_o(offs_o),
    .idx_o(idx_o), .accum_o(accum_o), .busy_o(busy_o), .done_o(done_o)
  );

  int n_chk = 0, n_err = 0;
  int rng [NL];
  int laddr [NL];
  int nops [NL];
  logic [OPW-1:0] code [LEN];
  logic [RWD-1:0] ro [NRO];
  logic [RWD-1:0] mreg [NR];

  typedef struct {
    int i0; int i1; logic [31:0] o0; logic [31:0] o1; logic acc;
  } row_t;
  row_t tbl [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [OPW-1:0] mk_op(input bit sel, input int a, input int b);
    return {sel, RW'(a), RW'(b)};
  endfunction

  task automatic apply_cfg();
    for (int l = 0; l < NL; l++) begin
      loop_addr_i[l*AW +: AW]         = AW'(laddr[l]);
      loop_nops_i[l*(AW+1) +: AW+1]   = (AW+1)'(nops[l]);
      range_i[l*CW +: CW]             = CW'(rng[l]);
    end
    for (int s = 0; s < LEN; s++) code_i[s*OPW +: OPW] = code[s];
    for (int k = 0; k < NRO; k++) ro_reg_i[k*RWD +: RWD] = ro[k];
  endtask

  // Two-loop program: loop0 reg0 += ro0 (4), loop1 reg1 += ro1 (100).
  task automatic cfg_base();
    for (int l = 0; l < NL; l++) begin rng[l] = 0; laddr[l] = 0; nops[l] = 0; end
    for (int s = 0; s < LEN; s++) code[s] = '0;
    for (int k = 0; k < NRO; k++) ro[k] = '0;
    rng[0] = 3; rng[1] = 2;
    laddr[0] = 0; nops[0] = 1; code[0] = mk_op(1'b1, 0, NR + 0);
    laddr[1] = 1; nops[1] = 1; code[1] = mk_op(1'b1, 1, NR + 1);
    ro[0] = 32'd4; ro[1] = 32'd100;
    accum_loop_i = '0;
    apply_cfg();
  endtask

  task automatic start_pulse();
    start_i = 1'b1; step(); start_i = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int w;
    w = 0;
    while (!valid_o && w < 20) begin step(); w++; end
    chk(name, valid_o, 1'b1);
  endtask

  task automatic check_row(input string tag, input int r);
    chk($sformatf("%s_row%0d", tag, r),
        {valid_o, accum_o, idx_o[23:0], offs_o[63:0]},
        {1'b1, tbl[r].acc, CW'(tbl[r].i1), CW'(tbl[r].i0), tbl[r].o1, tbl[r].o0});
  endtask

  task automatic run_table(input int base, input int n, input int stall_row, input int stall_len);
    start_pulse();
    for (int r = 0; r < n; r++) begin
      wait_valid($sformatf("tbl_valid_row%0d", base + r));
      if (r == stall_row) begin
        ready_i = 1'b0;
        for (int s = 0; s < stall_len; s++) begin check_row("stall", base + r); step(); end
      end
      ready_i = 1'b1;
      check_row("emit", base + r);
      step();
    end
    chk("tbl_done", {valid_o, done_o}, 2'b01);
    step();
    chk("tbl_idle", {busy_o, done_o}, 2'b00);
  endtask

  // Reference model: emission k is the number k written in mixed radix.
  function automatic int radix(input int l);
    return (rng[l] == 0) ? 1 : rng[l];
  endfunction

  function automatic int digit(input int k, input int l);
    int d;
    d = k;
    for (int j = 0; j < l; j++) d = d / radix(j);
    return d % radix(l);
  endfunction

  function automatic int adv_loop(input int k);
    for (int j = NL - 1; j >= 0; j--)
      if (digit(k + 1, j) != digit(k, j)) return j;
    return 0;
  endfunction

  task automatic model_ops(input int l);
    logic [OPW-1:0] w;
    int a, b, s;
    logic [RWD-1:0] v;
    for (int i = 0; i < nops[l]; i++) begin
      s = (laddr[l] + i) % LEN;
      w = code[s];
      a = int'(w[9:5]);
      b = int'(w[4:0]);
      v = (b < NR) ? mreg[b] : ro[b - NR];
      if (a < NR) mreg[a] = w[10] ? mreg[a] + v : v;
    end
  endtask

  task automatic rand_seq(input int t);
    int total, prod, r, k, cyc, hs, gap, l;
    bit seen, acc;
    logic [NL*CW-1:0] e_idx;
    logic [NR*RWD-1:0] e_offs;
    prod = 1;
    for (int j = 0; j < NL; j++) begin
      r = $urandom_range(0, 3);
      if (prod * ((r == 0) ? 1 : r) > 40) r = 1;
      rng[j] = r;
      prod = prod * radix(j);
      laddr[j] = $urandom_range(0, LEN - 1);
      nops[j] = $urandom_range(0, 3);
    end
    total = prod;
    for (int s = 0; s < LEN; s++)
      code[s] = mk_op(1'($urandom_range(0, 1)), $urandom_range(0, NR + 1), $urandom_range(0, 31));
    for (int q = 0; q < NRO; q++) ro[q] = $urandom;
    accum_loop_i = LW'($urandom_range(0, 7));
    apply_cfg();
    for (int q = 0; q < NR; q++) mreg[q] = '0;
    start_pulse();
    k = 0; cyc = 0; hs = -1; gap = 1; seen = 1'b0;
    while (k < total && cyc < 4000) begin
      ready_i = ($urandom_range(0, 3) != 0);
      start_i = 1'($urandom_range(0, 1));
      if (valid_o) begin
        if (!seen) begin
          chk($sformatf("rnd%0d_gap%0d", t, k), 128'(cyc - hs), 128'(gap));
          seen = 1'b1;
        end
        acc = 1'b1;
        for (int j = 0; j < NL; j++) begin
          e_idx[j*CW +: CW] = CW'(digit(k, j));
          if (j < int'(accum_loop_i) && digit(k, j) != 0) acc = 1'b0;
        end
        for (int q = 0; q < NR; q++) e_offs[q*RWD +: RWD] = mreg[q];
        chk($sformatf("rnd%0d_idx%0d", t, k), {accum_o, idx_o}, {acc, e_idx});
        chk($sformatf("rnd%0d_offs%0d", t, k), offs_o, e_offs);
        if (ready_i) begin
          if (k + 1 < total) begin
            l = adv_loop(k);
            model_ops(l);
            gap = nops[l] + 1;
          end
          hs = cyc; seen = 1'b0; k++;
        end
      end
      step(); cyc++;
    end
    start_i = 1'b0;
    if (k < total) begin
      chk($sformatf("rnd%0d_emissions", t), 128'(k), 128'(total));
      clear_i = 1'b1; step(); clear_i = 1'b0;
    end else begin
      chk($sformatf("rnd%0d_done", t), {valid_o, done_o}, 2'b01);
      step();
    end
    chk($sformatf("rnd%0d_idle", t), {busy_o, done_o}, 2'b00);
  endtask

  initial begin
    // rows 0..5: two-loop program; rows 6..9: ranges {2,2}, accum level 1
    tbl[0] = '{0, 0, 32'd0,  32'd0,   1'b1};
    tbl[1] = '{1, 0, 32'd4,  32'd0,   1'b1};
    tbl[2] = '{2, 0, 32'd8,  32'd0,   1'b1};
    tbl[3] = '{0, 1, 32'd8,  32'd100, 1'b1};
    tbl[4] = '{1, 1, 32'd12, 32'd100, 1'b1};
    tbl[5] = '{2, 1, 32'd16, 32'd100, 1'b1};
    tbl[6] = '{0, 0, 32'd0,  32'd0,   1'b1};
    tbl[7] = '{1, 0, 32'd4,  32'd0,   1'b0};
    tbl[8] = '{0, 1, 32'd4,  32'd100, 1'b1};
    tbl[9] = '{1, 1, 32'd8,  32'd100, 1'b0};

    cfg_base();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    chk("rst_ctrl", {valid_o, busy_o, done_o, accum_o}, 4'b0001);
    chk("rst_offs", offs_o, '0);
    chk("rst_idx", idx_o, '0);

    // basic sequence, then with a 5-cycle stall on the third emission
    run_table(0, 6, -1, 0);
    run_table(0, 6, 2, 5);

    // all ranges zero: a single emission
    for (int l = 0; l < NL; l++) rng[l] = 0;
    apply_cfg();
    start_pulse();
    chk("zero_rng_emit", {valid_o, idx_o, offs_o}, {1'b1, 72'd0, 128'd0});
    ready_i = 1'b1; step();
    chk("zero_rng_done", {valid_o, done_o}, 2'b01);
    step();
    chk("zero_rng_idle", {busy_o, done_o}, 2'b00);

    // accumulation level
    cfg_base();
    rng[0] = 2; rng[1] = 2; apply_cfg();
    accum_loop_i = 3'd1;
    run_table(6, 4, -1, 0);
    accum_loop_i = 3'd0;

    // clear together with start, then clear mid-EXEC
    cfg_base();
    clear_i = 1'b1; start_i = 1'b1; step(); clear_i = 1'b0; start_i = 1'b0;
    chk("clr_start", busy_o, 1'b0);
    start_pulse();
    ready_i = 1'b1; step();
    wait_valid("clr_e1_valid");
    chk("clr_e1_offs", offs_o[31:0], 32'd4);
    step();
    chk("clr_in_exec", {valid_o, busy_o}, 2'b01);
    clear_i = 1'b1; step(); clear_i = 1'b0;
    chk("clr_ctrl", {busy_o, valid_o, done_o}, 3'b000);
    chk("clr_regs", {idx_o, offs_o}, '0);
    step();
    chk("clr_no_done", {busy_o, done_o}, 2'b00);
    run_table(0, 6, -1, 0);

    // asynchronous reset mid-sequence
    start_pulse();
    step();
    wait_valid("rst_e1_valid");
    step();
    wait_valid("rst_e2_valid");
    rst_ni = 1'b0; #1;
    chk("arst_ctrl", {busy_o, valid_o, done_o}, 3'b000);
    chk("arst_regs", {idx_o, offs_o}, '0);
    step(); rst_ni = 1'b1; step();
    chk("arst_no_done", {busy_o, done_o}, 2'b00);
    run_table(0, 6, -1, 0);

    // move then add with wrap, and enable freezes in EXEC and EMIT
    cfg_base();
    rng[0] = 3; rng[1] = 0;
    laddr[0] = 2; nops[0] = 2;
    code[2] = mk_op(1'b0, 0, NR + 2);
    code[3] = mk_op(1'b1, 0, NR + 0);
    ro[0] = 32'd1; ro[2] = 32'hFFFF_FFFF;
    apply_cfg();
    start_pulse();
    chk("wrap_e0", {valid_o, idx_o[11:0], offs_o[31:0]}, {1'b1, 12'd0, 32'd0});
    ready_i = 1'b1; step();
    enable_i = 1'b0; #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("frz_exec%0d", s), {valid_o, busy_o, offs_o[31:0]}, {2'b01, 32'd0});
      step();
    end
    enable_i = 1'b1; step();
    chk("wrap_move", {valid_o, offs_o[31:0]}, {1'b0, 32'hFFFF_FFFF});
    step();
    chk("wrap_e1", {valid_o, idx_o[11:0], offs_o[31:0]}, {1'b1, 12'd1, 32'd0});
    enable_i = 1'b0; #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("frz_emit%0d", s), {valid_o, idx_o[11:0], offs_o[31:0]}, {1'b0, 12'd1, 32'd0});
      step();
    end
    enable_i = 1'b1; #1;
    chk("frz_resume", {valid_o, idx_o[11:0]}, {1'b1, 12'd1});
    step();
    wait_valid("wrap_e2_valid");
    chk("wrap_e2", {idx_o[11:0], offs_o[31:0]}, {12'd2, 32'd0});
    step();
    chk("wrap_done", {valid_o, done_o}, 2'b01);
    step();

    for (int t = 0; t < 10; t++) rand_seq(t);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
